// File: rtl/fc_input_buffer_if.sv
// Stream-in / vector-read bundle between the upstream word source, fc_input_buffer
// and the MAC datapath that reads the assembled vector by address.
interface fc_input_buffer_if #(
   parameter int unsigned T  = 16,
   parameter int unsigned N  = 8,
   parameter int unsigned AW = $clog2(N)
);
   logic          input_valid;
   logic          input_ready;
   logic [T-1:0]  input_data;
   logic          vec_ready;
   logic [AW-1:0] rd_addr;
   logic [T-1:0]  rd_data;
   logic          vec_done;

   modport master (
      output input_valid, input_data, rd_addr, vec_done,
      input  input_ready, vec_ready, rd_data
   );

   modport slave (
      input  input_valid, input_data, rd_addr, vec_done,
      output input_ready, vec_ready, rd_data
   );
endinterface

// File: rtl/fc_input_buffer.sv
// Serial-to-vector input buffer for the fc_* layers. Define FC_INBUF_DOUBLE_EN for
// ping-pong banking; otherwise a single bank blocks input until the vector is released.
module fc_input_buffer #(
   parameter int unsigned T  = 16,
   parameter int unsigned N  = 8,
   parameter int unsigned AW = $clog2(N)
) (
   input logic              clk,
   input logic              reset,
   fc_input_buffer_if.slave bus
);

`ifdef FC_INBUF_DOUBLE_EN
   localparam int unsigned NB = 2;
`else
   localparam int unsigned NB = 1;
`endif
   localparam int unsigned IW = $clog2(NB * N);

   logic [T-1:0]  mem [NB*N];
   logic [1:0]    full;
   logic [1:0]    full_nxt;
   logic          wr_bank;
   logic          rd_bank;
   logic [AW-1:0] wr_ptr;

   logic          ready;
   logic          xfer;
   logic          last;
   logic          release_v;
   logic          rd_in_range;
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] rd_idx;

   always_comb begin
      ready     = !reset && !full[wr_bank];
      xfer      = bus.input_valid && ready;
      last      = (wr_ptr == AW'(N - 1));
      release_v = bus.vec_done && full[rd_bank];
      wr_idx    = IW'(wr_bank ? N : 0) + IW'(wr_ptr);
      rd_idx    = IW'(rd_bank ? N : 0) + IW'(bus.rd_addr);
   end

   assign bus.input_ready = ready;
   assign bus.vec_ready   = full[rd_bank];

   // Out-of-range addresses only exist when N is not a power of two.
   if ((2 ** AW) == N) begin : g_rd_full_range
      assign rd_in_range = 1'b1;
   end else begin : g_rd_partial_range
      assign rd_in_range = (32'(bus.rd_addr) < N);
   end

   // Release and completion never target the same bank, so applying both is safe.
   always_comb begin
      full_nxt = full;
      if (release_v) full_nxt[rd_bank] = 1'b0;
      if (xfer && last) full_nxt[wr_bank] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         full        <= '0;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         wr_ptr      <= '0;
         bus.rd_data <= '0;
      end else begin
         full <= full_nxt;
         if (xfer) wr_ptr <= last ? '0 : wr_ptr + 1'b1;
`ifdef FC_INBUF_DOUBLE_EN
         if (xfer && last) wr_bank <= ~wr_bank;
         if (release_v) rd_bank <= ~rd_bank;
`endif
         if (rd_in_range) bus.rd_data <= mem[rd_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (xfer) mem[wr_idx] <= bus.input_data;
   end

endmodule

// File: tb/tb_fc_input_buffer.sv
// Self-checking bench for fc_input_buffer: a queue-of-vectors reference model checked
// every cycle, plus directed literal checks; honours FC_INBUF_DOUBLE_EN like the RTL.
module tb_fc_input_buffer;
   localparam int T  = 16;
   localparam int N  = 8;
   localparam int AW = $clog2(N);
`ifdef FC_INBUF_DOUBLE_EN
   localparam int NB = 2;
`else
   localparam int NB = 1;
`endif

   typedef logic [T-1:0] word_t;
   typedef word_t vec_t [N];

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fc_input_buffer_if #(.T(T), .N(N), .AW(AW)) bus ();

   fc_input_buffer #(.T(T), .N(N), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int    total = 0;
   int    bad   = 0;
   vec_t  vecs[$];
   word_t partial[$];
   word_t exp_rd;
   bit    rd_known = 1'b0;
   bit    started  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: completed vectors queue in arrival order, at most NB of them held.
   always @(posedge clk) begin
      int   sz;
      bit   acc;
      bit   rel;
      vec_t v;
      sz = vecs.size();
      if (reset) begin
         vecs.delete();
         partial.delete();
         exp_rd   = '0;
         rd_known = 1'b1;
         started  = 1'b1;
      end else begin
         if (sz > 0 && int'(bus.rd_addr) < N) begin
            exp_rd   = vecs[0][bus.rd_addr];
            rd_known = 1'b1;
         end else begin
            rd_known = 1'b0;
         end
         acc = bus.input_valid && (sz < NB);
         rel = bus.vec_done && (sz > 0);
         if (rel) void'(vecs.pop_front());
         if (acc) begin
            partial.push_back(bus.input_data);
            if (partial.size() == N) begin
               foreach (v[i]) v[i] = partial[i];
               vecs.push_back(v);
               partial.delete();
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("input_ready", {31'd0, bus.input_ready}, {31'd0, (!reset && vecs.size() < NB)});
         check("vec_ready", {31'd0, bus.vec_ready}, {31'd0, (vecs.size() > 0)});
         if (rd_known) check("rd_data", {16'd0, bus.rd_data}, {16'd0, exp_rd});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input word_t d, input bit done_with_it);
      int waited;
      waited = 0;
      bus.input_data  = d;
      bus.input_valid = 1'b1;
      while (!bus.input_ready && waited < 200) begin
         tick();
         waited++;
      end
      if (!bus.input_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got input_ready=0 want 1 within 200 cycles (word %h)", d);
         bus.input_valid = 1'b0;
      end else begin
         bus.vec_done = done_with_it;
         tick();
         bus.input_valid = 1'b0;
         bus.vec_done    = 1'b0;
      end
   endtask

   task automatic release_vec();
      bus.vec_done = 1'b1;
      tick();
      bus.vec_done = 1'b0;
   endtask

   task automatic read_word(input int a, output word_t d);
      bus.rd_addr = AW'(a);
      tick();
      d = bus.rd_data;
   endtask

   initial begin
      word_t d;
      int    accepted;
      int    cycles;
      bit    r;
      bit    v;
      bus.input_valid = 1'b0;
      bus.input_data  = '0;
      bus.rd_addr     = '0;
      bus.vec_done    = 1'b0;

      // Reset then idle
      repeat (3) tick();
      check("reset_input_ready", {31'd0, bus.input_ready}, 32'd0);
      check("reset_vec_ready", {31'd0, bus.vec_ready}, 32'd0);
      check("reset_rd_data", {16'd0, bus.rd_data}, 32'd0);
      reset = 1'b0;
      #1;
      check("release_input_ready", {31'd0, bus.input_ready}, 32'd1);
      check("release_vec_ready", {31'd0, bus.vec_ready}, 32'd0);
      release_vec();
      check("idle_done_vec_ready", {31'd0, bus.vec_ready}, 32'd0);
      check("idle_done_input_ready", {31'd0, bus.input_ready}, 32'd1);

      // Stream 1..8 back to back, then sweep
      for (int i = 0; i < N; i++) begin
         send_word(word_t'(i + 1), 1'b0);
         if (i == N - 2) check("vec_ready_before_last", {31'd0, bus.vec_ready}, 32'd0);
      end
      check("fill_latency", {31'd0, bus.vec_ready}, 32'd1);
      for (int a = 0; a < N; a++) begin
         read_word(a, d);
         check("sweep", {16'd0, d}, 32'(a + 1));
      end
      release_vec();
      check("released_vec_ready", {31'd0, bus.vec_ready}, 32'd0);

      // Vectors A and B with gaps, no release
      for (int i = 0; i < N; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         send_word(word_t'(16'h8000 + i), 1'b0);
      end
`ifdef FC_INBUF_DOUBLE_EN
      check("ready_after_A", {31'd0, bus.input_ready}, 32'd1);
      for (int i = 0; i < N; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         send_word(word_t'(16'h7FFF - i), 1'b0);
      end
`endif
      check("ready_when_full", {31'd0, bus.input_ready}, 32'd0);
      bus.input_data  = 16'hDEAD;
      bus.input_valid = 1'b1;
      repeat (4) tick();
      bus.input_valid = 1'b0;
      read_word(0, d);
      check("A_word0", {16'd0, d}, 32'h8000);
      read_word(N - 1, d);
      check("A_word7", {16'd0, d}, 32'h8007);
      release_vec();
`ifdef FC_INBUF_DOUBLE_EN
      check("B_still_ready", {31'd0, bus.vec_ready}, 32'd1);
      read_word(0, d);
      check("B_word0", {16'd0, d}, 32'h7FFF);
      read_word(N - 1, d);
      check("B_word7", {16'd0, d}, 32'h7FF8);
      release_vec();
`endif
      check("AB_drained", {31'd0, bus.vec_ready}, 32'd0);

`ifdef FC_INBUF_DOUBLE_EN
      // Release coincides with completion of the next vector
      for (int i = 0; i < N; i++) send_word(word_t'(16'h1000 + i), 1'b0);
      for (int i = 0; i < N - 1; i++) send_word(word_t'(16'h2000 + i), 1'b0);
      send_word(word_t'(16'h2000 + N - 1), 1'b1);
      check("overlap_vec_ready", {31'd0, bus.vec_ready}, 32'd1);
      read_word(0, d);
      check("overlap_word0", {16'd0, d}, 32'h2000);
      read_word(N - 1, d);
      check("overlap_word7", {16'd0, d}, 32'h2007);
      release_vec();
      check("overlap_drained", {31'd0, bus.vec_ready}, 32'd0);
`endif

      // Reset in the middle of a vector
      for (int i = 0; i < 5; i++) send_word(word_t'(16'h5500 + i), 1'b0);
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      #1;
      check("midreset_input_ready", {31'd0, bus.input_ready}, 32'd1);
      check("midreset_vec_ready", {31'd0, bus.vec_ready}, 32'd0);
      for (int i = 0; i < N; i++) send_word(word_t'(16'h0100 + i), 1'b0);
      check("midreset_fill", {31'd0, bus.vec_ready}, 32'd1);
      read_word(0, d);
      check("midreset_word0", {16'd0, d}, 32'h0100);
      read_word(4, d);
      check("midreset_word4", {16'd0, d}, 32'h0104);
      read_word(N - 1, d);
      check("midreset_word7", {16'd0, d}, 32'h0107);
      release_vec();

      // Randomized stream
      accepted = 0;
      cycles   = 0;
      while (accepted < 10000 && cycles < 60000) begin
         v               = ($urandom_range(0, 3) != 0);
         bus.input_valid = v;
         bus.input_data  = word_t'($urandom);
         bus.vec_done    = ($urandom_range(0, 3) == 0);
         bus.rd_addr     = AW'($urandom_range(0, N - 1));
         r               = bus.input_ready;
         tick();
         if (v && r) accepted++;
         cycles++;
      end
      bus.input_valid = 1'b0;
      bus.vec_done    = 1'b0;
      if (accepted < 10000) begin
         total++;
         bad++;
         $display("FAIL random_budget: got %0d accepted words want 10000", accepted);
      end

      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
